// File: rtl/conv_seq_pkg.sv
// Shared types, default widths and the result-count helper for the convolution host sequencer.
package conv_seq_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;
    localparam int Z_W_DEF    = 16;

    // Wide enough that NZ never overflows for any supported ADDR_W
    localparam int NZ_CALC_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        LOAD_Y,
        START,
        WAIT_DONE,
        RD_REQ,
        RD_CAP,
        RD_HOLD
    } state_t;

    function automatic logic [NZ_CALC_W-1:0] calcNz(
        input logic [NZ_CALC_W-1:0] sizeX,
        input logic [NZ_CALC_W-1:0] sizeY
    );
        return sizeX + sizeY - NZ_CALC_W'(1);
    endfunction

endpackage

// File: rtl/conv_seq_out_reg.sv
// Result holding register: captures one Z word with its last flag and holds it until the
// downstream ready handshake, or until the sequencer abandons the job.
module conv_seq_out_reg
    import conv_seq_pkg::*;
#(
    parameter int W = Z_W_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         capture_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         last_o
);

    logic [W-1:0] data_q;
    logic         valid_q;
    logic         last_q;

    // Abort beats capture and handshake; the data word itself is left as-is once consumed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (capture_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
            last_q  <= last_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: rtl/conv_host_sequencer.sv
// Host-side initiator: loads X then Y into the processor memories, starts it, and streams Z out.
// Optional WAIT_DONE watchdog (parameter TMO_CYC, output tmo_o) enabled by CONV_SEQ_TIMEOUT_EN.
module conv_host_sequencer
    import conv_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
`ifdef CONV_SEQ_TIMEOUT_EN
    parameter int TMO_CYC = 1024,
`endif
    parameter int Z_W     = Z_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              go_i,
    input  logic [ADDR_W:0]   size_x_i,
    input  logic [ADDR_W:0]   size_y_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              x_we_o,
    output logic              y_we_o,
    output logic [ADDR_W-1:0] xy_addr_o,
    output logic [DATA_W-1:0] xy_data_o,
    output logic              start_o,
    input  logic              busy_i,
    input  logic              done_i,
    output logic              z_rd_o,
    output logic [ADDR_W:0]   z_addr_o,
    input  logic [Z_W-1:0]    z_data_i,
    output logic [Z_W-1:0]    out_data_o,
    output logic              out_valid_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic              err_o,
`ifdef CONV_SEQ_TIMEOUT_EN
    output logic              tmo_o,
`endif
    output logic              seq_busy_o
);

    localparam int ZA_W = ADDR_W + 1;
    localparam int SZ_W = ADDR_W + 1;
    localparam int NZ_W = ZA_W + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ZA_W-1:0]   zIdx_q, zIdx_d;
    logic [SZ_W-1:0]   sizeX_q, sizeX_d;
    logic [SZ_W-1:0]   sizeY_q, sizeY_d;
    logic              err_q, err_d;
    logic              start_q, start_d;

    logic              inReady;
    logic              xWe;
    logic              yWe;
    logic              zRd;
    logic              capture;
    logic              clearOut;
    logic              outValid;
    logic              outLast;
    logic              loadDone;
    logic              isLast;
    logic              sizeBad;
    logic [SZ_W-1:0]   curSize;
    logic [NZ_W-1:0]   nz;

`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0]  tmoCnt_q, tmoCnt_d;
    logic              tmo_q, tmo_d;
    logic              tmoExpired;

    assign tmoExpired = (tmoCnt_q == TMO_W'(TMO_CYC - 1));
    assign tmo_o      = tmo_q;
`endif

    function automatic logic sizeIllegal(input logic [SZ_W-1:0] s);
        return (s == '0) || (s[ADDR_W] && (s[ADDR_W-1:0] != '0));
    endfunction

    assign sizeBad  = sizeIllegal(size_x_i) || sizeIllegal(size_y_i);
    assign curSize  = (state_q == LOAD_Y) ? sizeY_q : sizeX_q;
    assign loadDone = ({1'b0, idx_q} == (curSize - SZ_W'(1)));
    assign nz       = NZ_W'(calcNz(NZ_CALC_W'(sizeX_q), NZ_CALC_W'(sizeY_q)));
    assign isLast   = ({1'b0, zIdx_q} == (nz - NZ_W'(1)));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        zIdx_d   = zIdx_q;
        sizeX_d  = sizeX_q;
        sizeY_d  = sizeY_q;
        err_d    = 1'b0;
        start_d  = 1'b0;
        inReady  = 1'b0;
        xWe      = 1'b0;
        yWe      = 1'b0;
        zRd      = 1'b0;
        capture  = 1'b0;
        clearOut = 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
        tmoCnt_d = '0;
        tmo_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (go_i) begin
                    sizeX_d = size_x_i;
                    sizeY_d = size_y_i;
                    idx_d   = '0;
                    if (sizeBad) err_d   = 1'b1;
                    else         state_d = LOAD_X;
                end
            end
            LOAD_X: begin
                inReady = 1'b1;
                xWe     = in_valid_i;
                if (abort_i) begin
                    state_d = IDLE;
                end else if (in_valid_i) begin
                    if (loadDone) begin
                        idx_d   = '0;
                        state_d = LOAD_Y;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LOAD_Y: begin
                inReady = 1'b1;
                yWe     = in_valid_i;
                if (abort_i) begin
                    state_d = IDLE;
                end else if (in_valid_i) begin
                    if (loadDone) begin
                        idx_d   = '0;
                        state_d = START;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            // The processor cannot be cancelled, so abort is not looked at here or in WAIT_DONE
            START: begin
                if (!busy_i) begin
                    start_d = 1'b1;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_i) begin
                    zIdx_d  = '0;
                    state_d = RD_REQ;
                end
`ifdef CONV_SEQ_TIMEOUT_EN
                else if (tmoExpired) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
`endif
            end
            RD_REQ: begin
                zRd = 1'b1;
                if (abort_i) state_d = IDLE;
                else         state_d = RD_CAP;
            end
            RD_CAP: begin
                capture = 1'b1;
                state_d = RD_HOLD;
            end
            RD_HOLD: begin
                if (abort_i) begin
                    clearOut = 1'b1;
                    state_d  = IDLE;
                end else if (outValid && out_ready_i) begin
                    if (outLast) begin
                        state_d = IDLE;
                    end else begin
                        zIdx_d  = zIdx_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            zIdx_q   <= '0;
            sizeX_q  <= '0;
            sizeY_q  <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
            tmoCnt_q <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            zIdx_q   <= zIdx_d;
            sizeX_q  <= sizeX_d;
            sizeY_q  <= sizeY_d;
            err_q    <= err_d;
            start_q  <= start_d;
`ifdef CONV_SEQ_TIMEOUT_EN
            tmoCnt_q <= tmoCnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    conv_seq_out_reg #(
        .W (Z_W)
    ) u_outReg (
        .clk       (clk),
        .rstn      (rstn),
        .capture_i (capture),
        .clear_i   (clearOut),
        .data_i    (z_data_i),
        .last_i    (isLast),
        .ready_i   (out_ready_i),
        .data_o    (out_data_o),
        .valid_o   (outValid),
        .last_o    (outLast)
    );

    // Address/data buses are zeroed when idle so nothing toggles on the memory ports
    assign in_ready_o  = inReady;
    assign x_we_o      = xWe;
    assign y_we_o      = yWe;
    assign xy_addr_o   = (xWe || yWe) ? idx_q : '0;
    assign xy_data_o   = (xWe || yWe) ? in_data_i : '0;
    assign z_rd_o      = zRd;
    assign z_addr_o    = zRd ? zIdx_q : '0;
    assign out_valid_o = outValid;
    assign out_last_o  = outLast;
    assign start_o     = start_q;
    assign err_o       = err_q;
    assign seq_busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_conv_host_sequencer.sv
// Directed + randomized bench for conv_host_sequencer with a processor/memory model and a
// transaction-level reference (expected writes and result stream derived from job sizes).
module tb_conv_host_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int Z_W    = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              go_i = 1'b0;
    logic [ADDR_W:0]   size_x_i = '0;
    logic [ADDR_W:0]   size_y_i = '0;
    logic              abort_i = 1'b0;
    logic [DATA_W-1:0] in_data_i = '0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic              x_we_o;
    logic              y_we_o;
    logic [ADDR_W-1:0] xy_addr_o;
    logic [DATA_W-1:0] xy_data_o;
    logic              start_o;
    logic              busy_i = 1'b0;
    logic              done_i = 1'b0;
    logic              z_rd_o;
    logic [ADDR_W:0]   z_addr_o;
    logic [Z_W-1:0]    z_data_i = '0;
    logic [Z_W-1:0]    out_data_o;
    logic              out_valid_o;
    logic              out_last_o;
    logic              out_ready_i = 1'b0;
    logic              err_o;
    logic              seq_busy_o;
`ifdef CONV_SEQ_TIMEOUT_EN
    logic              tmo_o;
`endif

    conv_host_sequencer #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
`ifdef CONV_SEQ_TIMEOUT_EN
        .TMO_CYC (16),
`endif
        .Z_W     (Z_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .go_i        (go_i),
        .size_x_i    (size_x_i),
        .size_y_i    (size_y_i),
        .abort_i     (abort_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .x_we_o      (x_we_o),
        .y_we_o      (y_we_o),
        .xy_addr_o   (xy_addr_o),
        .xy_data_o   (xy_data_o),
        .start_o     (start_o),
        .busy_i      (busy_i),
        .done_i      (done_i),
        .z_rd_o      (z_rd_o),
        .z_addr_o    (z_addr_o),
        .z_data_i    (z_data_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .err_o       (err_o),
`ifdef CONV_SEQ_TIMEOUT_EN
        .tmo_o       (tmo_o),
`endif
        .seq_busy_o  (seq_busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Processor memories and Z read port model
    logic [DATA_W-1:0] xMem [32];
    logic [DATA_W-1:0] yMem [32];
    logic [Z_W-1:0]    zMem [64];
    always @(posedge clk) if (z_rd_o) z_data_i <= zMem[z_addr_o];

    int          xWrites = 0;
    int          yWrites = 0;
    int          startCount = 0;
    int          startCyc = 0;
    int          errCount = 0;
    int          busyCount = 0;
    int          holdViol = 0;
    int          tmoCount = 0;
    int          tmoCyc = 0;
    logic        heldValid = 1'b0;
    logic [15:0] heldData = '0;
    logic        heldLast = 1'b0;
    logic [16:0] outQ [$];

    // Observes every DUT transaction mid-cycle and accumulates what actually happened
    always @(negedge clk) begin
        if (x_we_o) begin xMem[xy_addr_o] = xy_data_o; xWrites++; end
        if (y_we_o) begin yMem[xy_addr_o] = xy_data_o; yWrites++; end
        if (start_o) begin startCount++; startCyc = cyc; end
        if (err_o) errCount++;
        if (seq_busy_o) busyCount++;
`ifdef CONV_SEQ_TIMEOUT_EN
        if (tmo_o) begin tmoCount++; tmoCyc = cyc; end
`endif
        if (heldValid && (!out_valid_o || out_data_o !== heldData || out_last_o !== heldLast))
            holdViol++;
        heldValid = out_valid_o && !out_ready_i;
        heldData  = out_data_o;
        heldLast  = out_last_o;
        if (out_valid_o && out_ready_i) outQ.push_back({out_last_o, out_data_o});
    end

    int compared = 0;
    int mismatched = 0;
    logic [DATA_W-1:0] sampleQ [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int sx, input int sy);
        @(posedge clk); #1;
        go_i     = 1'b1;
        size_x_i = (ADDR_W+1)'(sx);
        size_y_i = (ADDR_W+1)'(sy);
        @(posedge clk); #1;
        go_i     = 1'b0;
    endtask

    task automatic feedSamples(input int first, input int count, input bit gaps);
        int k;
        k = first;
        for (int t = 0; t < 4000 && k < first + count; t++) begin
            @(posedge clk); #1;
            in_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data_i  = sampleQ[k];
            @(negedge clk);
            if (in_valid_i && in_ready_o) k++;
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic runJob(input int sx, input int sy, input bit gaps, input bit randReady,
                          input bit stallWord2, input int busyCycles, input bit countData, input string tag);
        int nz, xBase, yBase, sBase, oBase, hBase, fallCyc, stallLeft, got;
        nz        = sx + sy - 1;
        xBase     = xWrites;
        yBase     = yWrites;
        sBase     = startCount;
        oBase     = outQ.size();
        hBase     = holdViol;
        fallCyc   = 0;
        stallLeft = 5;
        for (int i = 0; i < 64; i++) zMem[i] = 16'($urandom);
        sampleQ.delete();
        for (int i = 0; i < sx + sy; i++) sampleQ.push_back(countData ? 8'(i + 1) : 8'($urandom));
        busy_i = (busyCycles > 0);

        applyStimulus(sx, sy);
        feedSamples(0, sx + sy, gaps);
        if (busyCycles > 0) begin
            repeat (busyCycles) @(posedge clk);
            #1;
            busy_i  = 1'b0;
            fallCyc = cyc;
        end
        for (int t = 0; t < 300 && startCount == sBase; t++) @(posedge clk);
        #1;
        if (busyCycles > 0) checkOutput({tag, " start_cycle"}, startCyc, fallCyc + 1);

        repeat (2) @(posedge clk);
        #1 done_i = 1'b1;
        @(posedge clk);
        #1 done_i = 1'b0;

        for (int t = 0; t < 3000 && (outQ.size() - oBase) < nz; t++) begin
            @(posedge clk); #1;
            if (stallWord2 && out_valid_o && (outQ.size() - oBase) == 1 && stallLeft > 0) begin
                out_ready_i = 1'b0;
                stallLeft--;
            end else begin
                out_ready_i = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
        for (int t = 0; t < 50 && seq_busy_o; t++) begin @(posedge clk); #1; end
        out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        got = outQ.size() - oBase;
        checkOutput({tag, " idle"}, seq_busy_o, 0);
        checkOutput({tag, " words"}, got, nz);
        for (int i = 0; i < nz && i < got; i++) begin
            checkOutput($sformatf("%s z%0d", tag, i), outQ[oBase + i][15:0], zMem[i]);
            checkOutput($sformatf("%s last%0d", tag, i), outQ[oBase + i][16], (i == nz - 1));
        end
        checkOutput({tag, " x_writes"}, xWrites - xBase, sx);
        checkOutput({tag, " y_writes"}, yWrites - yBase, sy);
        for (int i = 0; i < sx; i++) checkOutput($sformatf("%s x%0d", tag, i), xMem[i], sampleQ[i]);
        for (int i = 0; i < sy; i++) checkOutput($sformatf("%s y%0d", tag, i), yMem[i], sampleQ[sx + i]);
        checkOutput({tag, " start_pulses"}, startCount - sBase, 1);
        checkOutput({tag, " hold_stable"}, holdViol - hBase, 0);
    endtask

    task automatic checkIllegal(input int sx, input int sy, input string tag);
        int eBase, bBase, wBase;
        eBase = errCount;
        bBase = busyCount;
        wBase = xWrites + yWrites;
        applyStimulus(sx, sy);
        repeat (4) @(posedge clk);
        #1;
        checkOutput({tag, " err_pulses"}, errCount - eBase, 1);
        checkOutput({tag, " busy_cycles"}, busyCount - bBase, 0);
        checkOutput({tag, " writes"}, xWrites + yWrites - wBase, 0);
    endtask

    initial begin
        int xBase, yBase, sBase;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst seq_busy", seq_busy_o, 0);
        checkOutput("rst in_ready", in_ready_o, 0);
        checkOutput("rst out_valid", out_valid_o, 0);
        checkOutput("rst out_last", out_last_o, 0);
        checkOutput("rst out_data", out_data_o, 0);
        checkOutput("rst start", start_o, 0);
        checkOutput("rst err", err_o, 0);
        checkOutput("rst x_we", x_we_o, 0);
        checkOutput("rst y_we", y_we_o, 0);
        checkOutput("rst z_rd", z_rd_o, 0);
        checkOutput("rst z_addr", z_addr_o, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        runJob(3, 2, 1'b0, 1'b0, 1'b0, 0, 1'b1, "basic");
        runJob(5, 4, 1'b1, 1'b0, 1'b1, 0, 1'b0, "gaps_stall");
        runJob(2, 3, 1'b0, 1'b0, 1'b0, 4, 1'b0, "busy_wait");

        checkIllegal(0, 3, "ill_x0");
        checkIllegal(3, 0, "ill_y0");
        checkIllegal(33, 1, "ill_x33");

        // Abort partway through the Y load, then a minimal 1x1 job
        sampleQ.delete();
        for (int i = 0; i < 7; i++) sampleQ.push_back(8'($urandom));
        xBase = xWrites;
        yBase = yWrites;
        sBase = startCount;
        applyStimulus(4, 3);
        feedSamples(0, 5, 1'b0);
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        checkOutput("abort seq_busy", seq_busy_o, 0);
        checkOutput("abort in_ready", in_ready_o, 0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("abort x_writes", xWrites - xBase, 4);
        checkOutput("abort y_writes", yWrites - yBase, 1);
        checkOutput("abort no_start", startCount - sBase, 0);
        runJob(1, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, "after_abort");

        // Asynchronous reset mid-load
        sampleQ.delete();
        for (int i = 0; i < 6; i++) sampleQ.push_back(8'($urandom));
        applyStimulus(3, 3);
        feedSamples(0, 2, 1'b0);
        #2 rstn = 1'b0;
        #1;
        checkOutput("areset seq_busy", seq_busy_o, 0);
        checkOutput("areset in_ready", in_ready_o, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        runJob(32, 32, 1'b1, 1'b1, 1'b0, 0, 1'b0, "max");
        runJob(32, 1, 1'b0, 1'b1, 1'b1, 1, 1'b0, "x32y1");
        for (int j = 0; j < 3; j++)
            runJob($urandom_range(1, 32), $urandom_range(1, 32), 1'($urandom_range(0, 1)), 1'b1,
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, $sformatf("rand%0d", j));

`ifdef CONV_SEQ_TIMEOUT_EN
        begin
            int tBase, stBase;
            sampleQ.delete();
            sampleQ.push_back(8'($urandom));
            sampleQ.push_back(8'($urandom));
            tBase  = tmoCount;
            stBase = startCount;
            applyStimulus(1, 1);
            feedSamples(0, 2, 1'b0);
            for (int t = 0; t < 100 && startCount == stBase; t++) @(posedge clk);
            for (int t = 0; t < 100 && tmoCount == tBase; t++) @(posedge clk);
            #1;
            checkOutput("tmo pulses", tmoCount - tBase, 1);
            checkOutput("tmo delay", tmoCyc - startCyc, 16);
            checkOutput("tmo idle", seq_busy_o, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/conv_host_sequencer.md
Name: conv_host_sequencer

Overview:
Host-side initiator for the convolution processor. It streams X then Y samples from an input valid/ready stream into the processor's X and Y memories, then pulses start. It waits for the processor's done pulse and reads the Z result memory out onto an output valid/ready stream. It sits between the system bus/DMA stream and the processor datapath/FSM pair.

Parameters:
DATA_W, 8, width of X/Y samples
ADDR_W, 5, X/Y memory address width; max size_x/size_y = 2**ADDR_W
Z_W, 16, width of Z results
Localparam ZA_W = ADDR_W+1, Z memory address width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
go_i  in  1  one-cycle request to run a full job; sampled only in IDLE
size_x_i  in  ADDR_W+1  X length, latched on go_i
size_y_i  in  ADDR_W+1  Y length, latched on go_i
abort_i  in  1  synchronous abort; honoured in LOAD_X, LOAD_Y, RD_REQ, RD_HOLD only
in_data_i  in  DATA_W  input sample
in_valid_i  in  1  input sample valid
in_ready_o  out  1  accepting input
x_we_o  out  1  X memory write enable
y_we_o  out  1  Y memory write enable
xy_addr_o  out  ADDR_W  X/Y write address
xy_data_o  out  DATA_W  X/Y write data
start_o  out  1  one-cycle start pulse to processor
busy_i  in  1  processor busy
done_i  in  1  processor one-cycle done pulse
z_rd_o  out  1  Z memory read strobe
z_addr_o  out  ZA_W  Z read address
z_data_i  in  Z_W  Z read data, valid 1 cycle after z_rd_o
out_data_o  out  Z_W  result word
out_valid_o  out  1  result valid
out_last_o  out  1  marks final result word
out_ready_i  in  1  downstream ready
err_o  out  1  one-cycle pulse: illegal size on go_i
seq_busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE. All outputs 0, and counters cleared.
- States: IDLE, LOAD_X, LOAD_Y, START, WAIT_DONE, RD_REQ, RD_CAP, RD_HOLD.
- IDLE: on go_i, latch sizes and clear idx.
  - Size 0 or > 2**ADDR_W on either size: pulse err_o next cycle and stay IDLE.
  - Otherwise go to LOAD_X.
- LOAD_X/LOAD_Y: in_ready_o=1 combinationally. On in_valid_i&&in_ready_o, assert x_we_o (or y_we_o) in the same cycle with xy_addr_o=idx and xy_data_o=in_data_i, then idx++.
  - When the write with idx==size-1 occurs, clear idx and advance (LOAD_X->LOAD_Y->START).
  - Input stalls (in_valid_i low) hold all state.
- START: wait for !busy_i, then drive start_o=1 for exactly one cycle and go to WAIT_DONE. start_o never re-asserts until the next job.
- WAIT_DONE: ignore busy_i; on done_i go to RD_REQ with zidx=0. A done_i seen in any other state is ignored.
- Result count NZ = size_x+size_y-1, computed in ZA_W+1 bits; no overflow at max sizes.
- RD_REQ: z_rd_o=1, z_addr_o=zidx, then RD_CAP.
- RD_CAP: register z_data_i into out_data_o, set out_valid_o, set out_last_o=(zidx==NZ-1), then RD_HOLD.
- RD_HOLD: hold out_data_o, out_valid_o and out_last_o stable until out_ready_i.
  - On the handshake, clear out_valid_o.
  - If last, go to IDLE; otherwise zidx++ and go to RD_REQ.
  - Maximum throughput is one word per 3 cycles.
- abort_i (in an honoured state): next state IDLE; out_valid_o, in_ready_o and all strobes deasserted next cycle; no start_o issued.
- abort_i is ignored in START and WAIT_DONE, because the processor cannot be cancelled.
- go_i outside IDLE is ignored.
- Asynchronous reset mid-job returns to IDLE immediately; partially loaded memories are not cleared.

Optional Feature:
Macro CONV_SEQ_TIMEOUT_EN.
- When defined: add parameter TMO_CYC (default 1024) and output tmo_o.
  - A counter runs in WAIT_DONE.
  - If TMO_CYC cycles elapse without done_i: pulse tmo_o for one cycle and go to IDLE.
  - If done_i arrives on the same cycle as expiry, done wins.
- When undefined: no counter, no tmo_o port, and WAIT_DONE waits indefinitely.

Decomposition:
- Package conv_seq_pkg holds:
  - the state enum typedef (state_t, 3-bit);
  - a function computing NZ from the two sizes;
  - default width constants.
- One sub-module is natural: conv_seq_out_reg, the output holding register with valid/last and the ready handshake, reused by the RD states.

Test Plan:
- go_i with size_x=3, size_y=2, input 1,2,3,4,5 at full rate -> x_we_o at addr 0..2 with 1,2,3; y_we_o at addr 0..1 with 4,5; one start_o pulse; after done_i, 4 words out with out_last_o on the 4th.
- Input with in_valid_i gaps, and out_ready_i low for 5 cycles on word 2 -> no lost or duplicated writes; out_data_o is stable while held.
- go_i with size_x=0 -> err_o pulses once, seq_busy_o stays 0, no memory writes.
- busy_i high on entry to START for 4 cycles -> start_o asserts only on the cycle after busy_i falls.
- abort_i during LOAD_Y, then a new go_i with sizes 1,1 -> returns to IDLE; the second job completes with exactly 1 output word, out_last_o=1.
- With CONV_SEQ_TIMEOUT_EN and TMO_CYC=16, no done_i -> tmo_o pulses 16 cycles after entering WAIT_DONE, then state is IDLE.
